axi_read_responder: RTL and testbench

- AXI4 read subordinate (responder) that accepts read bursts on AR and returns beats on R.
- Converts each burst into per-beat reads on a native single-port memory interface with fixed 1-cycle read latency.
- Pairs with the write-side initiator helpers: this is the far end of the same AXI link, used to expose Versat-side memories to an external AXI manager.
- Sustains one beat per cycle under continuous RREADY.

---
 rtl/axi_read_responder.sv | 135 +++++++++++++
 tb/tb_axi_read_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_responder.sv
// AXI4 read subordinate: turns AR bursts into per-beat reads on a 1-cycle-latency
// native memory port and streams the results back on R through a 2-entry FIFO.
module axi_read_responder #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 4,
  parameter int AXI_LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AXI_ID_W-1:0]   s_axi_arid,
  input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
  input  logic [AXI_LEN_W-1:0]  s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [AXI_ID_W-1:0]   s_axi_rid,
  output logic [AXI_DATA_W-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  mem_en_o,
  output logic [AXI_ADDR_W-1:0] mem_addr_o,
  input  logic [AXI_DATA_W-1:0] mem_rdata_i
);

  localparam int                    CNT_W     = AXI_LEN_W + 1;
  localparam logic [2:0]            MAX_SIZE  = 3'($clog2(AXI_DATA_W / 8));
  localparam logic [AXI_ADDR_W-1:0] PAGE_MASK = AXI_ADDR_W'(4095);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q, state_d;
  logic [AXI_ID_W-1:0]   id_q;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [AXI_LEN_W-1:0]  len_q;
  logic [2:0]            size_q;
  logic                  fixed_q;
  logic                  err_q;
  logic [CNT_W-1:0]      iss_cnt_q;
  logic [CNT_W-1:0]      ret_cnt_q;
  logic                  pend_q;
  logic [1:0]            count_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [AXI_DATA_W-1:0] fifo_mem [2];

  logic                  ar_hs, pop, issue, last_beat, err_in;
  logic [2:0]            occ;
  logic [AXI_ADDR_W-1:0] size_bytes, inc_addr, next_addr;
  logic [AXI_DATA_W-1:0] push_data;

  assign ar_hs     = s_axi_arvalid & s_axi_arready;
  assign pop       = s_axi_rvalid & s_axi_rready;
  assign last_beat = (ret_cnt_q == {1'b0, len_q});
  assign err_in    = s_axi_arburst[1] | (s_axi_arsize > MAX_SIZE);

  // Occupancy credits the beat leaving this cycle so reads can stream back-to-back.
  assign occ   = 3'(count_q) + 3'(pend_q) - 3'(pop);
  assign issue = (state_q == BURST) && (iss_cnt_q <= {1'b0, len_q}) && (occ < 3'd2);

  assign size_bytes = AXI_ADDR_W'(1) << size_q;
  assign inc_addr   = (addr_q & ~(size_bytes - AXI_ADDR_W'(1))) + size_bytes;
  assign next_addr  = fixed_q ? addr_q : ((addr_q & ~PAGE_MASK) | (inc_addr & PAGE_MASK));
  assign push_data  = err_q ? '0 : mem_rdata_i;

  assign mem_en_o     = issue & ~err_q;
  assign mem_addr_o   = addr_q;
  assign s_axi_rvalid = (count_q != 2'd0);
  assign s_axi_rdata  = s_axi_rvalid ? fifo_mem[rd_ptr_q] : '0;
  assign s_axi_rresp  = (s_axi_rvalid && err_q) ? 2'b10 : 2'b00;
  assign s_axi_rlast  = s_axi_rvalid & last_beat;
  assign s_axi_rid    = id_q;

  always_comb begin
    state_d       = state_q;
    s_axi_arready = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) state_d = BURST;
      end
      BURST: if (pop && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      fixed_q   <= 1'b0;
      err_q     <= 1'b0;
      iss_cnt_q <= '0;
      ret_cnt_q <= '0;
      pend_q    <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= issue;
      if (ar_hs) begin
        id_q      <= s_axi_arid;
        addr_q    <= s_axi_araddr;
        len_q     <= s_axi_arlen;
        size_q    <= s_axi_arsize;
        fixed_q   <= (s_axi_arburst == 2'b00);
        err_q     <= err_in;
        iss_cnt_q <= '0;
        ret_cnt_q <= '0;
      end else begin
        if (issue) begin
          addr_q    <= next_addr;
          iss_cnt_q <= iss_cnt_q + CNT_W'(1);
        end
        if (pop) ret_cnt_q <= ret_cnt_q + CNT_W'(1);
      end
      if (pend_q) wr_ptr_q <= ~wr_ptr_q;
      if (pop)    rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(pend_q) - 2'(pop);
    end
  end

  // NOTE: FIFO storage is deliberately not reset; rdata is gated by rvalid, so stale entries never leak out.
  always_ff @(posedge clk) begin
    if (pend_q) fifo_mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed self-checking bench for axi_read_responder with a 1-cycle-latency memory model.
module tb_axi_read_responder;

  localparam int AW = 32, DW = 32, IW = 4, LW = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [IW-1:0] arid = '0;
  logic [AW-1:0] araddr = '0;
  logic [LW-1:0] arlen = '0;
  logic [2:0]    arsize = '0;
  logic [1:0]    arburst = '0;
  logic          arvalid = 1'b0, arready;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready = 1'b0;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;

  axi_read_responder #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW), .AXI_LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'hA5A5_0000 ^ a;
  endfunction

  always @(posedge clk) if (mem_en) mem_rdata <= mem_word(mem_addr);

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    int            cyc;
  } beat_t;

  int            cyc = 0;
  logic [AW-1:0] addr_log[$];
  int            addr_cyc[$];
  beat_t         beat_q[$];
  int            ar_cyc = -1;
  int            ar_cnt = 0;
  logic          stall_seen = 1'b0;
  beat_t         stall_beat;
  int            stable_err = 0;
  logic          track_en = 1'b0;
  int            outstanding = 0;
  int            occ_err = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (rst_n) begin
    if (mem_en) begin
      addr_log.push_back(mem_addr);
      addr_cyc.push_back(cyc);
    end
    if (rvalid && rready) beat_q.push_back('{rid, rdata, rresp, rlast, cyc});
    if (arvalid && arready) begin
      ar_cyc = cyc;
      ar_cnt++;
    end
    if (stall_seen && rvalid &&
        (rid !== stall_beat.id || rdata !== stall_beat.data ||
         rresp !== stall_beat.resp || rlast !== stall_beat.last)) stable_err++;
    stall_seen = rvalid && !rready;
    stall_beat = '{rid, rdata, rresp, rlast, cyc};
    if (track_en) begin
      outstanding += int'(mem_en) - int'(rvalid && rready);
      if (outstanding > 2) occ_err++;
    end
  end

  task automatic clear_logs();
    addr_log.delete();
    addr_cyc.delete();
    beat_q.delete();
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [LW-1:0] len, input logic [2:0] size, input logic [1:0] burst);
    int t;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (arready) break;
      if (++t > 200) begin
        check("ar_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1 arvalid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int t;
    t = 0;
    while (beat_q.size() < n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("beat_count", beat_q.size(), n);
  endtask

  initial begin
    logic [AW-1:0] exp_a [4];
    int k;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", arready, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rid", rid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // INCR 0x100 len3 size2, continuous rready
    rready = 1'b1;
    clear_logs();
    send_ar(4'h5, 32'h100, 8'd3, 3'd2, 2'b01);
    check("t1_arready_busy", arready, 0);
    wait_beats(4);
    check("t1_addr_cnt", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size() && i < beat_q.size(); i++) begin
      check($sformatf("t1_addr%0d", i), addr_log[i], 32'h100 + 4 * i);
      check($sformatf("t1_addr_cyc%0d", i), addr_cyc[i] - addr_cyc[0], i);
      check($sformatf("t1_data%0d", i), beat_q[i].data, 32'hA5A5_0100 + 4 * i);
      check($sformatf("t1_last%0d", i), beat_q[i].last, i == 3);
      check($sformatf("t1_resp%0d", i), beat_q[i].resp, 0);
      check($sformatf("t1_rid%0d", i), beat_q[i].id, 4'h5);
      check($sformatf("t1_beat_cyc%0d", i), beat_q[i].cyc - beat_q[0].cyc, i);
    end

    // INCR across the 4KB page boundary wraps inside the page
    clear_logs();
    send_ar(4'h2, 32'h1FF8, 8'd3, 3'd2, 2'b01);
    wait_beats(4);
    exp_a = '{32'h1FF8, 32'h1FFC, 32'h1000, 32'h1004};
    check("t2_addr_cnt", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size() && i < beat_q.size(); i++) begin
      check($sformatf("t2_addr%0d", i), addr_log[i], exp_a[i]);
      check($sformatf("t2_data%0d", i), beat_q[i].data, mem_word(exp_a[i]));
    end

    // FIXED burst repeats the start address
    clear_logs();
    send_ar(4'h7, 32'h40, 8'd2, 3'd2, 2'b00);
    wait_beats(3);
    check("t3_addr_cnt", addr_log.size(), 3);
    for (int i = 0; i < 3 && i < addr_log.size() && i < beat_q.size(); i++) begin
      check($sformatf("t3_addr%0d", i), addr_log[i], 32'h40);
      check($sformatf("t3_last%0d", i), beat_q[i].last, i == 2);
    end

    // Unaligned INCR start: first beat unmodified, then aligned increment
    clear_logs();
    send_ar(4'h1, 32'h102, 8'd1, 3'd2, 2'b01);
    wait_beats(2);
    check("t3u_addr_cnt", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      check("t3u_addr0", addr_log[0], 32'h102);
      check("t3u_addr1", addr_log[1], 32'h104);
    end

    // rready pattern 1,0,0 repeating over 8 beats
    clear_logs();
    outstanding = 0;
    occ_err = 0;
    stable_err = 0;
    track_en = 1'b1;
    send_ar(4'hA, 32'h200, 8'd7, 3'd2, 2'b01);
    k = 0;
    while (beat_q.size() < 8 && k < 500) begin
      rready = (k % 3 == 0);
      @(posedge clk);
      #1;
      k++;
    end
    track_en = 1'b0;
    rready = 1'b1;
    check("t4_beat_count", beat_q.size(), 8);
    check("t4_addr_cnt", addr_log.size(), 8);
    for (int i = 0; i < 8 && i < beat_q.size() && i < addr_log.size(); i++) begin
      check($sformatf("t4_addr%0d", i), addr_log[i], 32'h200 + 4 * i);
      check($sformatf("t4_data%0d", i), beat_q[i].data, 32'hA5A5_0200 + 4 * i);
      check($sformatf("t4_last%0d", i), beat_q[i].last, i == 7);
    end
    if (addr_cyc.size() == 8) check("t4_mem_stalled", (addr_cyc[7] - addr_cyc[0]) > 7, 1);
    check("t4_payload_stable", stable_err, 0);
    check("t4_fifo_bound", occ_err, 0);

    // WRAP burst returns SLVERR without touching memory; next AR accepted one cycle after rlast
    clear_logs();
    send_ar(4'h3, 32'h80, 8'd1, 3'd2, 2'b10);
    arid = 4'h6; araddr = 32'h300; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    k = ar_cnt;
    for (int t = 0; t < 200 && ar_cnt == k; t++) @(posedge clk);
    #1 arvalid = 1'b0;
    check("t5_ar_accepted", ar_cnt, k + 1);
    wait_beats(3);
    if (beat_q.size() == 3) begin
      check("t5_resp0", beat_q[0].resp, 2'b10);
      check("t5_resp1", beat_q[1].resp, 2'b10);
      check("t5_data0", beat_q[0].data, 0);
      check("t5_data1", beat_q[1].data, 0);
      check("t5_last0", beat_q[0].last, 0);
      check("t5_last1", beat_q[1].last, 1);
      check("t5_rid1", beat_q[1].id, 4'h3);
      check("t5_dead_cycle", ar_cyc - beat_q[1].cyc, 1);
      check("t5_next_data", beat_q[2].data, 32'hA5A5_0300);
      check("t5_next_last", beat_q[2].last, 1);
      check("t5_next_rid", beat_q[2].id, 4'h6);
    end
    check("t5_mem_cnt", addr_log.size(), 1);
    if (addr_log.size() == 1) check("t5_mem_addr", addr_log[0], 32'h300);

    // Reset in the middle of an 8-beat burst
    clear_logs();
    send_ar(4'h4, 32'h400, 8'd7, 3'd2, 2'b01);
    k = 0;
    while (beat_q.size() < 2 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1 rst_n = 1'b0;
    #1;
    check("t6_rvalid_in_rst", rvalid, 0);
    check("t6_mem_en_in_rst", mem_en, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_arready_after", arready, 1);
    check("t6_no_stale_beats", beat_q.size(), 2);
    send_ar(4'h9, 32'h500, 8'd1, 3'd2, 2'b01);
    wait_beats(4);
    if (beat_q.size() == 4) begin
      check("t6_data0", beat_q[2].data, 32'hA5A5_0500);
      check("t6_data1", beat_q[3].data, 32'hA5A5_0504);
      check("t6_last", beat_q[3].last, 1);
      check("t6_rid", beat_q[3].id, 4'h9);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
